autotieoff_monitor: RTL and testbench



---
 rtl/autotieoff_monitor.sv | 160 ++++++++++++++++
 tb/tb_autotieoff_monitor.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/autotieoff_monitor.sv
// Tie-off checker: registers four tied-off buses and verifies them against their tie values
// over a WINDOW-cycle check. Optional first-mismatch capture under AUTOTIEOFF_MON_CAPTURE_EN.
module autotieoff_monitor #(
  parameter int         WINDOW     = 16,
  parameter int         CNT_W      = 8,
  parameter logic [2:0] EXTRA_TIE  = 3'h0,
  parameter logic [2:0] SUB_TIE    = 3'h0,
  parameter logic [3:0] ACTLOW_TIE = 4'h0,
  parameter logic [3:0] IGN_TIE    = 4'h0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             ignore_en,
  input  logic [2:0]       ExtraIn,
  input  logic [2:0]       SubIn,
  input  logic [3:0]       active_low_l,
  input  logic [3:0]       ignored_by_regexp,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic [3:0]       err_vec
`ifdef AUTOTIEOFF_MON_CAPTURE_EN
  ,
  output logic [13:0]      first_bad,
  output logic             first_bad_valid
`endif
);

  localparam int PW = (WINDOW > 1) ? $clog2(WINDOW) : 1;

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, REPORT} state_t;

  state_t            state, state_n;
  logic [PW-1:0]     cyc, cyc_n;
  logic [2:0]        cap_extra, cap_sub;
  logic [3:0]        cap_actlow, cap_ign;
  logic [3:0]        mis_vec;
  logic              mis, accept, upd, fin;
  logic [CNT_W-1:0]  cnt_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_extra  <= '0;
      cap_sub    <= '0;
      cap_actlow <= '0;
      cap_ign    <= '0;
    end else begin
      cap_extra  <= ExtraIn;
      cap_sub    <= SubIn;
      cap_actlow <= active_low_l;
      cap_ign    <= ignored_by_regexp;
    end
  end

  always_comb begin
    mis_vec[0] = (cap_extra != EXTRA_TIE);
    mis_vec[1] = (cap_sub != SUB_TIE);
    mis_vec[2] = (cap_actlow != ACTLOW_TIE);
    mis_vec[3] = (cap_ign != IGN_TIE) && !ignore_en;
    mis        = |mis_vec;
    cnt_n      = err_cnt;
    if (mis && (err_cnt != '1))
      cnt_n = err_cnt + 1'b1;
  end

  always_comb begin
    state_n = state;
    cyc_n   = cyc;
    accept  = 1'b0;
    upd     = 1'b0;
    fin     = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_n = SETTLE;
          cyc_n   = '0;
          accept  = 1'b1;
        end
      end
      SETTLE: begin
        if (abort) begin
          state_n = IDLE;
        end else if (cyc == PW'(1)) begin
          state_n = CHECK;
          cyc_n   = '0;
        end else begin
          cyc_n = cyc + 1'b1;
        end
      end
      CHECK: begin
        if (abort) begin
          state_n = IDLE;
        end else begin
          upd = 1'b1;
          if (cyc == PW'(WINDOW - 1)) begin
            state_n = REPORT;
            fin     = 1'b1;
          end else begin
            cyc_n = cyc + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state == SETTLE) || (state == CHECK);
  assign done = (state == REPORT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cyc   <= '0;
    end else begin
      state <= state_n;
      cyc   <= cyc_n;
    end
  end

  // pass is loaded from the post-increment count so the final CHECK cycle is included.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass    <= 1'b0;
      err_cnt <= '0;
      err_vec <= '0;
    end else if (accept) begin
      pass    <= 1'b0;
      err_cnt <= '0;
      err_vec <= '0;
    end else begin
      if (upd) begin
        err_cnt <= cnt_n;
        err_vec <= err_vec | mis_vec;
      end
      if (fin)
        pass <= (cnt_n == '0);
      if (abort && (state != IDLE))
        pass <= 1'b0;
    end
  end

`ifdef AUTOTIEOFF_MON_CAPTURE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_bad       <= '0;
      first_bad_valid <= 1'b0;
    end else if (accept) begin
      first_bad       <= '0;
      first_bad_valid <= 1'b0;
    end else if (upd && mis && !first_bad_valid) begin
      first_bad       <= {cap_extra, cap_sub, cap_actlow, cap_ign};
      first_bad_valid <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_autotieoff_monitor.sv
// Self-checking bench for autotieoff_monitor: directed and random checks against a
// per-check reference model; a second instance with CNT_W=2 exercises saturation.
module tb_autotieoff_monitor;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst, start, abort, ignore_en;
  logic [2:0] ex, sb;
  logic [3:0] al, ig;

  logic       busy0, done0, pass0, busy1, done1, pass1;
  logic [7:0] cnt0;
  logic [1:0] cnt1;
  logic [3:0] vec0, vec1;
`ifdef AUTOTIEOFF_MON_CAPTURE_EN
  logic [13:0] fb0, fb1;
  logic        fbv0, fbv1;
`endif

  int checks = 0;
  int errors = 0;

  logic [2:0] ex_a[W+3];
  logic [2:0] sb_a[W+3];
  logic [3:0] al_a[W+3];
  logic [3:0] ig_a[W+3];

  always #5 clk = ~clk;

  autotieoff_monitor #(.WINDOW(W), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .ignore_en(ignore_en),
    .ExtraIn(ex), .SubIn(sb), .active_low_l(al), .ignored_by_regexp(ig),
    .busy(busy0), .done(done0), .pass(pass0), .err_cnt(cnt0), .err_vec(vec0)
`ifdef AUTOTIEOFF_MON_CAPTURE_EN
    , .first_bad(fb0), .first_bad_valid(fbv0)
`endif
  );

  autotieoff_monitor #(.WINDOW(W), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .ignore_en(ignore_en),
    .ExtraIn(ex), .SubIn(sb), .active_low_l(al), .ignored_by_regexp(ig),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(cnt1), .err_vec(vec1)
`ifdef AUTOTIEOFF_MON_CAPTURE_EN
    , .first_bad(fb1), .first_bad_valid(fbv1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: samples present before edges 2..W+1 are the compared ones; all ties are 0.
  task automatic model(output int n, output logic [3:0] vec,
                       output logic [13:0] fb, output logic fbv);
    logic [3:0] m;
    n = 0; vec = '0; fb = '0; fbv = 1'b0;
    for (int j = 2; j <= W + 1; j++) begin
      m = {(ig_a[j] != 4'h0) && !ignore_en, al_a[j] != 4'h0, sb_a[j] != 3'h0, ex_a[j] != 3'h0};
      if (m != 4'h0) begin
        n++;
        if (!fbv) begin
          fbv = 1'b1;
          fb  = {ex_a[j], sb_a[j], al_a[j], ig_a[j]};
        end
      end
      vec = vec | m;
    end
  endtask

  task automatic fill_const(input logic [2:0] e, input logic [2:0] s,
                            input logic [3:0] a, input logic [3:0] i);
    for (int j = 0; j < W + 3; j++) begin
      ex_a[j] = e; sb_a[j] = s; al_a[j] = a; ig_a[j] = i;
    end
  endtask

  task automatic fill_rand();
    for (int j = 0; j < W + 3; j++) begin
      ex_a[j] = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'h0;
      sb_a[j] = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'h0;
      al_a[j] = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0;
      ig_a[j] = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0;
    end
  endtask

  task automatic drive(input int j);
    ex = ex_a[j]; sb = sb_a[j]; al = al_a[j]; ig = ig_a[j];
  endtask

  task automatic run_check(input bit mid_start, input bit rep_start);
    int          n;
    logic [3:0]  vec;
    logic [13:0] fb;
    logic        fbv;
    model(n, vec, fb, fbv);
    start = 1'b1;
    drive(0);
    for (int k = 0; k <= W + 2; k++) begin
      @(posedge clk); #1;
      start = (mid_start && k == 5) || (rep_start && k == W + 2);
      if (k < W + 2) drive(k + 1);
      if (k == 0) begin
        chk("start_busy", {busy0, busy1, done0, done1}, 4'b1100);
        chk("start_clear", {pass0, cnt0, vec0, pass1, cnt1, vec1}, '0);
      end else if (k < W + 2) begin
        chk("busy_run", {busy0, busy1, done0, done1}, 4'b1100);
      end else begin
        chk("done_pulse", {done0, done1, busy0, busy1}, 4'b1100);
        chk("pass0", pass0, n == 0);
        chk("cnt0", cnt0, (n > 255) ? 255 : n);
        chk("vec0", vec0, vec);
        chk("pass1", pass1, n == 0);
        chk("cnt1_sat", cnt1, (n > 3) ? 3 : n);
        chk("vec1", vec1, vec);
`ifdef AUTOTIEOFF_MON_CAPTURE_EN
        chk("fbv0", fbv0, fbv);
        chk("fb0", fb0, fb);
`endif
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
    chk("after_done", {busy0, busy1, done0, done1}, 4'b0000);
    chk("pass_held", pass0, n == 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; ignore_en = 1'b0;
    ex = '0; sb = '0; al = '0; ig = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", {busy0, done0, pass0, cnt0, vec0, busy1, done1, pass1, cnt1, vec1}, '0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_outs", {busy0, done0, pass0, cnt0, vec0}, '0);

    fill_const(3'h0, 3'h0, 4'h0, 4'h0);
    run_check(1'b0, 1'b0);

    fill_const(3'h0, 3'h0, 4'h0, 4'h0);
    for (int j = 5; j <= 7; j++) sb_a[j] = 3'h2;
    run_check(1'b0, 1'b0);

    fill_const(3'h0, 3'h0, 4'h0, 4'hF);
    ignore_en = 1'b1;
    run_check(1'b0, 1'b0);
    ignore_en = 1'b0;
    run_check(1'b0, 1'b0);

    fill_const(3'h0, 3'h0, 4'h1, 4'h0);
    run_check(1'b0, 1'b0);

    fill_const(3'h0, 3'h0, 4'h0, 4'h0);
    run_check(1'b1, 1'b1);

    // Abort in the fifth CHECK cycle with ExtraIn wrong throughout.
    fill_const(3'h1, 3'h0, 4'h0, 4'h0);
    start = 1'b1;
    drive(0);
    for (int k = 0; k <= 6; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      drive(k + 1);
      if (k == 6) abort = 1'b1;
    end
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_idle", {busy0, done0, pass0, busy1, done1, pass1}, '0);
    chk("abort_vec", {vec0, vec1}, 8'h11);
    chk("abort_cnt_range", (cnt0 >= 4) && (cnt0 <= 5), 1'b1);
    chk("abort_cnt1", cnt1, 2'd3);
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort_no_done", {done0, done1, busy0}, 3'b000);
    end
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("abort_beats_start", {busy0, busy1}, 2'b00);
    chk("abort_start_hold", vec0, 4'h1);
    fill_const(3'h0, 3'h0, 4'h0, 4'h0);
    run_check(1'b0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      fill_rand();
      ignore_en = 1'($urandom);
      run_check(1'b0, 1'b0);
    end
    ignore_en = 1'b0;

    // Asynchronous reset mid-CHECK, away from any clock edge.
    fill_const(3'h0, 3'h5, 4'h0, 4'h0);
    start = 1'b1;
    drive(0);
    for (int k = 0; k <= 6; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      drive(k + 1);
    end
    chk("pre_rst_errs", cnt0 != 8'h0, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst", {busy0, done0, pass0, cnt0, vec0, busy1, done1, pass1, cnt1, vec1}, '0);
`ifdef AUTOTIEOFF_MON_CAPTURE_EN
    chk("async_rst_fb", {fbv0, fb0}, '0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_idle", {busy0, done0, cnt0}, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
